// File: rtl/guess_game_controller.sv
// Round sequencer for the number-guessing game: latches difficulty, captures the target, scores guesses.
// Optional best-score tracking is enabled by defining GUESS_GAME_BEST_SCORE_EN.
module guess_game_controller #(
  parameter int unsigned MAX_ATTEMPTS = 10,
  parameter int unsigned ATT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       difficulty_level,
  input  logic             guess_valid,
  input  logic [9:0]       guess,
  input  logic [9:0]       number_in,
  output logic [1:0]       gen_difficulty,
  output logic             busy,
  output logic             too_high,
  output logic             too_low,
  output logic             correct,
  output logic             out_of_range,
  output logic [ATT_W-1:0] attempts,
  output logic             win,
  output logic             lose,
`ifdef GUESS_GAME_BEST_SCORE_EN
  output logic [ATT_W-1:0] best_score,
`endif
  output logic [9:0]       target
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       diff_q, diff_d;
  logic [9:0]       target_q, target_d;
  logic [ATT_W-1:0] att_q, att_d, att_inc;
  logic             hi_q, hi_d, lo_q, lo_d, eq_q, eq_d, oor_q, oor_d;
  logic [9:0]       limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      diff_q   <= '0;
      target_q <= '0;
      att_q    <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      eq_q     <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      diff_q   <= diff_d;
      target_q <= target_d;
      att_q    <= att_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      eq_q     <= eq_d;
      oor_q    <= oor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    target_d = target_q;
    att_d    = att_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    eq_d     = eq_q;
    oor_d    = oor_q;
    att_inc  = att_q + ATT_W'(1);
    case (diff_q)
      2'b01:   limit = 10'd9;
      2'b10:   limit = 10'd99;
      default: limit = 10'd999;
    endcase

    case (state_q)
      IDLE: begin
        if (start && difficulty_level != 2'b00) begin
          diff_d  = difficulty_level;
          state_d = LOAD;
        end
      end
      LOAD: begin
        target_d = number_in;
        att_d    = '0;
        hi_d     = 1'b0;
        lo_d     = 1'b0;
        eq_d     = 1'b0;
        oor_d    = 1'b0;
        state_d  = PLAY;
      end
      PLAY: begin
        // start is deliberately not examined here; only reset can abort a round
        if (guess_valid) begin
          if (guess > limit) begin
            oor_d = 1'b1;
            hi_d  = 1'b0;
            lo_d  = 1'b0;
            eq_d  = 1'b0;
          end else begin
            oor_d = 1'b0;
            hi_d  = guess > target_q;
            lo_d  = guess < target_q;
            eq_d  = guess == target_q;
            att_d = att_inc;
            if (guess == target_q)
              state_d = WIN;
            else if (att_inc == ATT_W'(MAX_ATTEMPTS))
              state_d = LOSE;
          end
        end
      end
      WIN, LOSE: begin
        if (start) begin
          if (difficulty_level != 2'b00) begin
            diff_d  = difficulty_level;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GUESS_GAME_BEST_SCORE_EN
  logic [ATT_W-1:0] best_q, best_d;

  always_comb begin
    best_d = best_q;
    if (state_q == PLAY && state_d == WIN && (best_q == '0 || att_d < best_q))
      best_d = att_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) best_q <= '0;
    else       best_q <= best_d;
  end

  assign best_score = best_q;
`endif

  assign gen_difficulty = (state_q == IDLE) ? 2'b00 : diff_q;
  assign busy           = (state_q == LOAD) || (state_q == PLAY);
  assign win            = (state_q == WIN);
  assign lose           = (state_q == LOSE);
  assign target         = (state_q == WIN || state_q == LOSE) ? target_q : '0;
  assign too_high       = hi_q;
  assign too_low        = lo_q;
  assign correct        = eq_q;
  assign out_of_range   = oor_q;
  assign attempts       = att_q;

endmodule

// File: tb/tb_guess_game_controller.sv
// Scoreboard bench for guess_game_controller: stimulus pushes model predictions, a monitor pops and compares.
module tb_guess_game_controller;
  localparam int unsigned MAXA = 10;
  localparam int unsigned AW   = 4;

  logic          clk = 1'b0;
  logic          reset, start, guess_valid;
  logic [1:0]    difficulty_level;
  logic [9:0]    guess, number_in;
  logic [1:0]    gen_difficulty;
  logic          busy, too_high, too_low, correct, out_of_range, win, lose;
  logic [AW-1:0] attempts;
  logic [9:0]    target;
`ifdef GUESS_GAME_BEST_SCORE_EN
  logic [AW-1:0] best_score;
`endif

  guess_game_controller #(.MAX_ATTEMPTS(MAXA), .ATT_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .difficulty_level(difficulty_level),
    .guess_valid(guess_valid), .guess(guess), .number_in(number_in),
    .gen_difficulty(gen_difficulty), .busy(busy), .too_high(too_high), .too_low(too_low),
    .correct(correct), .out_of_range(out_of_range), .attempts(attempts),
    .win(win), .lose(lose),
`ifdef GUESS_GAME_BEST_SCORE_EN
    .best_score(best_score),
`endif
    .target(target)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    int gd, busy, hi, lo, eq, oor, att, win, lose, tgt, best;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: round phase flags plus the game's visible quantities
  bit m_load, m_play, m_over, m_won, m_hi, m_lo, m_eq, m_oor;
  int m_diff, m_tgt, m_att, m_best;

  function automatic int lim_of(int d);
    int l = 1;
    for (int i = 0; i < d; i++) l = l * 10;
    return l - 1;
  endfunction

  task automatic model_reset();
    {m_load, m_play, m_over, m_won, m_hi, m_lo, m_eq, m_oor} = '0;
    m_diff = 0; m_tgt = 0; m_att = 0; m_best = 0;
  endtask

  task automatic model_step(bit r, bit s, int d, bit gv, int g, int n);
    if (r) begin
      model_reset();
    end else if (m_load) begin
      m_tgt = n; m_att = 0;
      {m_hi, m_lo, m_eq, m_oor} = '0;
      m_load = 0; m_play = 1;
    end else if (m_play) begin
      if (gv) begin
        if (g > lim_of(m_diff)) begin
          m_oor = 1; {m_hi, m_lo, m_eq} = '0;
        end else begin
          m_oor = 0; m_att++;
          m_hi = g > m_tgt; m_lo = g < m_tgt; m_eq = g == m_tgt;
          if (m_eq) begin
            m_play = 0; m_over = 1; m_won = 1;
            if (m_best == 0 || m_att < m_best) m_best = m_att;
          end else if (m_att == int'(MAXA)) begin
            m_play = 0; m_over = 1; m_won = 0;
          end
        end
      end
    end else if (m_over) begin
      if (s) begin
        m_over = 0;
        if (d != 0) begin m_diff = d; m_load = 1; end
      end
    end else if (s && d != 0) begin
      m_diff = d; m_load = 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.due  = cyc + 1;
    e.gd   = (m_load || m_play || m_over) ? m_diff : 0;
    e.busy = int'(m_load || m_play);
    e.hi = int'(m_hi); e.lo = int'(m_lo); e.eq = int'(m_eq); e.oor = int'(m_oor);
    e.att  = m_att;
    e.win  = int'(m_over && m_won);
    e.lose = int'(m_over && !m_won);
    e.tgt  = m_over ? m_tgt : 0;
    e.best = m_best;
    sbq.push_back(e);
  endtask

  task automatic step(bit r, bit s, int d, bit gv, int g, int n);
    @(posedge clk);
    #2;
    reset = r; start = s; difficulty_level = d[1:0];
    guess_valid = gv; guess = g[9:0]; number_in = n[9:0];
    model_step(r, s, d, gv, g, n);
    push_exp();
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(string name, logic [31:0] act, int exp_v, int unsigned c);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, c, act, exp_v);
    end
  endtask

  // Monitor: outputs are compared one time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("gen_difficulty", 32'(gen_difficulty), e.gd, e.due);
        chk("busy", 32'(busy), e.busy, e.due);
        chk("too_high", 32'(too_high), e.hi, e.due);
        chk("too_low", 32'(too_low), e.lo, e.due);
        chk("correct", 32'(correct), e.eq, e.due);
        chk("out_of_range", 32'(out_of_range), e.oor, e.due);
        chk("attempts", 32'(attempts), e.att, e.due);
        chk("win", 32'(win), e.win, e.due);
        chk("lose", 32'(lose), e.lose, e.due);
        chk("target", 32'(target), e.tgt, e.due);
`ifdef GUESS_GAME_BEST_SCORE_EN
        chk("best_score", 32'(best_score), e.best, e.due);
`endif
      end
    end
  end

  // One round at difficulty 11 with target 500: nwrong misses, then a hit if do_win
  task automatic play_round(int nwrong, bit do_win);
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 500);
    for (int i = 0; i < nwrong; i++) step(0, 0, 0, 1, 100, 0);
    if (do_win) step(0, 0, 0, 1, 500, 0);
    idle(1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; difficulty_level = '0;
    guess_valid = 1'b0; guess = '0; number_in = '0;
    model_reset();

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(1);

    // difficulty 01, target 7: low, high, correct
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7);
    step(0, 0, 0, 1, 3, 0);
    step(0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 1, 7, 0);
    step(0, 0, 0, 1, 2, 0);
    idle(1);

    // from WIN: difficulty 10, target 42, out-of-range then correct
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 42);
    step(0, 0, 0, 1, 150, 0);
    step(0, 0, 0, 1, 100, 0);
    step(0, 0, 0, 1, 99, 0);
    step(0, 0, 0, 1, 42, 0);
    idle(1);

    // difficulty 11, target 500: ten low guesses lose, eleventh ignored
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 500);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 100, 0);
    step(0, 0, 0, 1, 500, 0);
    idle(1);

    // start 00 from LOSE goes IDLE, start 00 in IDLE stays
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(1);

    // start during PLAY ignored, then reset mid-round with four attempts
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 2, 1, 2, 0);
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // best-score sequence: wins in 5, 3, 6 attempts, then a loss
    play_round(4, 1);
    play_round(2, 1);
    play_round(5, 1);
    play_round(10, 0);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      bit r, s, gv;
      int d, g, n;
      r  = ($urandom_range(199) == 0);
      s  = ($urandom_range(9) == 0);
      d  = $urandom_range(3);
      gv = $urandom_range(1);
      n  = $urandom_range(lim_of(m_diff == 0 ? 3 : m_diff));
      case ($urandom_range(3))
        0:       g = m_tgt;
        1:       g = $urandom_range(1023);
        default: g = $urandom_range(lim_of(m_diff == 0 ? 3 : m_diff));
      endcase
      step(r, s, d, gv, g, n);
    end

    idle(3);
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/guess_game_controller.md
Name: guess_game_controller

Overview:
- Sequences one round of the number-guessing game around the random-number generator.
- Latches difficulty and drives the generator's difficulty input, then captures the generated target.
- Accepts player guesses through a valid strobe, compares each against the target, counts attempts and reports win/lose.
- Sits between the input/debounce logic and the display/feedback logic.

Parameters:
- MAX_ATTEMPTS, 10, guesses allowed per round before LOSE; legal range 1..15.
- ATT_W, 4, width of the attempt counter; must satisfy 2^ATT_W > MAX_ATTEMPTS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a round.
- difficulty_level  input  2  01 = 0..9, 10 = 0..99, 11 = 0..999, 00 = invalid.
- guess_valid  input  1  single-cycle strobe qualifying guess.
- guess  input  10  player guess, unsigned.
- number_in  input  10  target value from the generator.
- gen_difficulty  output  2  difficulty driven to the generator.
- busy  output  1  high in LOAD and PLAY.
- too_high  output  1  last counted guess > target.
- too_low  output  1  last counted guess < target.
- correct  output  1  last counted guess == target.
- out_of_range  output  1  last guess exceeded the difficulty maximum.
- attempts  output  ATT_W  counted guesses this round.
- win  output  1  high in WIN state.
- lose  output  1  high in LOSE state.
- target  output  10  captured target; driven 0 except in WIN/LOSE (reveal).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; internal target and difficulty registers 0.
- States: IDLE, LOAD, PLAY, WIN, LOSE.
- IDLE:
  - On start with difficulty_level != 00: latch difficulty into diff_q, go to LOAD.
  - On start with difficulty_level == 00: ignore, stay in IDLE.
- LOAD (exactly 1 cycle):
  - gen_difficulty = diff_q.
  - At the end of the cycle: capture number_in into the target register, clear attempts and all flags, go to PLAY.
- gen_difficulty equals diff_q in LOAD, PLAY, WIN and LOSE; it is 00 in IDLE.
- PLAY:
  - guess_valid is evaluated every cycle.
  - Range limit: max = 9 / 99 / 999 for diff_q = 01 / 10 / 11.
  - guess > max: out_of_range=1 next cycle; other flags cleared; attempts unchanged; not counted.
  - In-range guess: exactly one of too_high/too_low/correct set the cycle after the strobe; out_of_range cleared; attempts increments by 1. Latency is 1 cycle.
  - Flags hold until the next guess_valid or a state exit.
  - Correct guess: go to WIN on the same edge as the counting.
  - Wrong guess that brings attempts to MAX_ATTEMPTS: go to LOSE on the same edge.
  - Correct on the final attempt resolves as WIN.
  - start in PLAY is ignored; a round cannot be restarted mid-play except by reset.
- WIN and LOSE:
  - win or lose held high; target output shows the captured value; attempts and flags frozen; guess_valid ignored.
  - start with a valid difficulty: latch the new difficulty, go to LOAD (win/lose drop the next cycle).
  - start with difficulty 00: go to IDLE.
- start and guess_valid in the same cycle in PLAY: start ignored, guess processed.
- The attempt counter never exceeds MAX_ATTEMPTS and never wraps.
- Reset asserted mid-round: immediate return to IDLE; the target is lost.

Optional Feature:
- Macro: GUESS_GAME_BEST_SCORE_EN.
- When defined:
  - Adds output best_score [ATT_W-1:0], reset to 0.
  - On every entry into WIN: if best_score == 0 or attempts < best_score, best_score <= attempts.
  - LOSE never updates it; it persists across rounds until reset.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset then start, difficulty 01, number_in=7; guesses 3, 9, 7 -> too_low, too_high, correct on successive cycles; attempts=3; win=1; target=7.
- Difficulty 10, number_in=42; guess 150 -> out_of_range=1, attempts stays 0; guess 42 -> correct, win=1, attempts=1.
- MAX_ATTEMPTS=10, difficulty 11, target 500; ten guesses of 100 -> too_low each time; lose=1 after the 10th; target=500; an 11th guess_valid is ignored.
- In PLAY with attempts=4, assert reset for 1 cycle -> state IDLE; all outputs 0; gen_difficulty=00.
- In WIN, start with difficulty 01 -> LOAD for one cycle, then PLAY with attempts=0 and flags 0; start with difficulty 00 in IDLE -> remains IDLE.
- GUESS_GAME_BEST_SCORE_EN: win in 5 attempts, then in 3, then in 6 -> best_score = 5, 3, 3; a subsequent lose leaves it at 3.
